// File: rtl/gcd_lcm_engine_pkg.sv
// -----------------------------------------------------------------------------
// gcd_lcm_pkg
//   Shared definitions for the GCD/LCM engine: FSM state encoding, the state
//   enum, and a constant-width helper used to size counters.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package gcd_lcm_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ENC_STRIP  = 3'd1;
    localparam logic [STATE_W-1:0] ENC_REDUCE = 3'd2;
    localparam logic [STATE_W-1:0] ENC_DIV    = 3'd3;
    localparam logic [STATE_W-1:0] ENC_MUL    = 3'd4;
    localparam logic [STATE_W-1:0] ENC_DONE   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_STRIP  = ENC_STRIP,
        ST_REDUCE = ENC_REDUCE,
        ST_DIV    = ENC_DIV,
        ST_MUL    = ENC_MUL,
        ST_DONE   = ENC_DONE
    } gcd_state_t;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2_w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_lcm_engine_if.sv
// -----------------------------------------------------------------------------
// gcd_lcm_engine_if
//   Operand / result handshake bundle for gcd_lcm_engine.
//   A, B, in_vld        : operand pair offered by the master
//   in_rdy              : engine idle and able to accept
//   gcd_out, lcm_out    : results, stable while out_vld is high
//   out_vld, out_rdy    : result handshake
//   busy                : engine is not idle
//   master = operand source / result sink, slave = the engine.
// -----------------------------------------------------------------------------
interface gcd_lcm_engine_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic                in_vld;
    logic                in_rdy;
    logic [DATA_W-1:0]   gcd_out;
    logic [2*DATA_W-1:0] lcm_out;
    logic                out_vld;
    logic                out_rdy;
    logic                busy;

    modport master (
        output A, B, in_vld, out_rdy,
        input  in_rdy, gcd_out, lcm_out, out_vld, busy
    );

    modport slave (
        input  A, B, in_vld, out_rdy,
        output in_rdy, gcd_out, lcm_out, out_vld, busy
    );
endinterface

// File: rtl/gcd_lcm_engine_div.sv
// -----------------------------------------------------------------------------
// gcd_div_seq
//   Restoring sequential divider, one quotient bit per cycle.
//   start    : load dividend/divisor (one-cycle pulse)
//   dividend : numerator, sampled on start
//   divisor  : denominator, sampled on start (must be non-zero)
//   done     : one-cycle pulse, quotient valid from this cycle on
//   quotient : dividend / divisor, held until the next start
//   Iterations run on the DATA_W cycles after start; done is registered and
//   rises the cycle after the final iteration.
// -----------------------------------------------------------------------------
module gcd_div_seq
    import gcd_lcm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);
    localparam int CNT_W = clog2_w(DATA_W + 1);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] quo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   trial;

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_W-1]};
        trial     = rem_shift - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= CNT_W'(DATA_W);
            end else if (cnt_q != '0) begin
                // Negative trial means the subtract did not fit: restore.
                if (trial[DATA_W]) begin
                    rem_q <= rem_shift[DATA_W-1:0];
                end else begin
                    rem_q <= trial[DATA_W-1:0];
                end
                quo_q <= {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/gcd_lcm_engine.sv
// -----------------------------------------------------------------------------
// gcd_lcm_engine
//   Sequential GCD (binary Stein algorithm) and LCM = (A / GCD) * B engine.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts any computation
//   io  : gcd_lcm_engine_if.slave operand/result handshake
//         (A, B, in_vld, in_rdy, gcd_out, lcm_out, out_vld, out_rdy, busy)
//   Zero operands bypass straight to DONE with gcd = A | B and lcm = 0.
//   Results are registered and held in DONE until out_rdy.
// -----------------------------------------------------------------------------
module gcd_lcm_engine
    import gcd_lcm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    gcd_lcm_engine_if.slave io
);
    localparam int K_W = clog2_w(DATA_W);

    gcd_state_t          state_q;
    gcd_state_t          state_d;

    logic [DATA_W-1:0]   a_q;        // Stein working copies
    logic [DATA_W-1:0]   b_q;
    logic [K_W-1:0]      k_q;        // common power-of-two factor
    logic [DATA_W-1:0]   a_sh_q;     // original operands for DIV/MUL
    logic [DATA_W-1:0]   b_sh_q;
    logic [DATA_W-1:0]   g_q;
    logic [DATA_W-1:0]   gcd_q;
    logic [2*DATA_W-1:0] lcm_q;
    logic                out_vld_q;

    logic                div_start;
    logic                div_done;
    logic [DATA_W-1:0]   div_quo;
    logic [DATA_W-1:0]   g_comb;
    logic [2*DATA_W-1:0] prod;
    logic                zero_in;

    assign zero_in = (io.A == '0) || (io.B == '0);
    assign g_comb  = a_q << k_q;
    // q = A/g <= A, so q*B <= A*B always fits the double-width product.
    assign prod    = (2*DATA_W)'(div_quo) * (2*DATA_W)'(b_sh_q);

    // Divider is launched on the REDUCE exit cycle using the combinational
    // g so that DIV starts iterating immediately.
    gcd_div_seq #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_sh_q),
        .divisor  (g_comb),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (io.in_vld) begin
                    state_d = zero_in ? ST_DONE : ST_STRIP;
                end
            end
            ST_STRIP: begin
                if (a_q[0] || b_q[0]) begin
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (a_q == b_q) begin
                    state_d   = ST_DIV;
                    div_start = 1'b1;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (io.out_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            g_q       <= '0;
            gcd_q     <= '0;
            lcm_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= (state_d == ST_DONE);
            unique case (state_q)
                ST_IDLE: begin
                    if (io.in_vld) begin
                        a_q    <= io.A;
                        b_q    <= io.B;
                        k_q    <= '0;
                        a_sh_q <= io.A;
                        b_sh_q <= io.B;
                        if (zero_in) begin
                            gcd_q <= io.A | io.B;
                            lcm_q <= '0;
                        end
                    end
                end
                ST_STRIP: begin
                    if (!a_q[0] && !b_q[0]) begin
                        a_q <= a_q >> 1;
                        b_q <= b_q >> 1;
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_REDUCE: begin
                    // One reduction per cycle; difference of two odds is even
                    // so the halving is folded into the subtract.
                    if (a_q == b_q) begin
                        g_q <= g_comb;
                    end else if (!a_q[0]) begin
                        a_q <= a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_q <= b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_q <= (a_q - b_q) >> 1;
                    end else begin
                        b_q <= (b_q - a_q) >> 1;
                    end
                end
                ST_MUL: begin
                    gcd_q <= g_q;
                    lcm_q <= prod;
                end
                default: begin
                end
            endcase
        end
    end

    assign io.in_rdy  = (state_q == ST_IDLE);
    assign io.busy    = (state_q != ST_IDLE);
    assign io.out_vld = out_vld_q;
    assign io.gcd_out = gcd_q;
    assign io.lcm_out = lcm_q;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// -----------------------------------------------------------------------------
// tb_gcd_lcm_engine
//   Drives an 8-bit and a 16-bit gcd_lcm_engine with directed and random
//   operand pairs and compares against a Euclid-based reference model.
// -----------------------------------------------------------------------------
module tb_gcd_lcm_engine;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic        o_vld;
    logic        o_inrdy;
    logic        o_busy;
    logic [15:0] o_gcd;
    logic [31:0] o_lcm;

    gcd_lcm_engine_if #(.DATA_W(8))  if8 ();
    gcd_lcm_engine_if #(.DATA_W(16)) if16 ();

    gcd_lcm_engine #(.DATA_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .io  (if8)
    );

    gcd_lcm_engine #(.DATA_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .io  (if16)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_gcd(input logic [15:0] a, input logic [15:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 16'(x);
    endfunction

    function automatic logic [31:0] m_lcm(input logic [15:0] a, input logic [15:0] b);
        longint p;
        if (a == 0 || b == 0) return 32'd0;
        p = longint'(a) * longint'(b);
        return 32'(p / longint'(m_gcd(a, b)));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input bit w);
        if (w) begin
            o_vld = if16.out_vld; o_inrdy = if16.in_rdy; o_busy = if16.busy;
            o_gcd = if16.gcd_out; o_lcm = if16.lcm_out;
        end else begin
            o_vld = if8.out_vld; o_inrdy = if8.in_rdy; o_busy = if8.busy;
            o_gcd = {8'h00, if8.gcd_out}; o_lcm = {16'h0000, if8.lcm_out};
        end
    endtask

    task automatic drive(input bit w, input logic [15:0] a, input logic [15:0] b,
                         input logic v, input logic ordy);
        if (w) begin
            if16.A = a; if16.B = b; if16.in_vld = v; if16.out_rdy = ordy;
        end else begin
            if8.A = a[7:0]; if8.B = b[7:0]; if8.in_vld = v; if8.out_rdy = ordy;
        end
    endtask

    // One full transaction. exp_lat > 0 demands an exact latency, otherwise
    // the worst-case bound is checked (zero operands always take one cycle).
    task automatic xact(input bit w, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input string tag, input int exp_lat);
        int          n;
        bit          rdy_bad;
        int          wd;
        logic [15:0] eg;
        logic [31:0] el;
        wd = w ? 16 : 8;
        eg = m_gcd(a, b);
        el = m_lcm(a, b);
        n  = 0;
        snap(w);
        while (!o_inrdy && n < 300) begin
            tick(); snap(w); n++;
        end
        chk({tag, ".idle"}, o_inrdy, 1);
        drive(w, a, b, 1'b1, hold == 0);
        tick();
        drive(w, a, b, 1'b0, hold == 0);
        n = 1;
        rdy_bad = 1'b0;
        snap(w);
        while (!o_vld && n < 400) begin
            if (o_inrdy || !o_busy) rdy_bad = 1'b1;
            tick(); snap(w); n++;
        end
        chk({tag, ".vld"}, o_vld, 1);
        chk({tag, ".gcd"}, o_gcd, eg);
        chk({tag, ".lcm"}, o_lcm, el);
        chk({tag, ".rdy_low"}, rdy_bad | o_inrdy, 0);
        if (a == 0 || b == 0)  chk({tag, ".lat0"}, n, 1);
        else if (exp_lat > 0)  chk({tag, ".lat"}, n, exp_lat);
        else                   chk({tag, ".lat_bound"}, n <= 5*wd + 4, 1);
        for (int i = 0; i < hold; i++) begin
            drive(w, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            tick(); snap(w);
            chk({tag, ".hold_vld"}, o_vld, 1);
            chk({tag, ".hold_gcd"}, o_gcd, eg);
            chk({tag, ".hold_lcm"}, o_lcm, el);
            chk({tag, ".hold_rdy"}, o_inrdy, 0);
        end
        drive(w, a, b, 1'b0, 1'b1);
        tick(); snap(w);
        chk({tag, ".drop"}, o_vld, 0);
        chk({tag, ".rdy_back"}, o_inrdy, 1);
        drive(w, a, b, 1'b0, 1'b0);
        if (hold > 0) begin
            tick(); snap(w);
            chk({tag, ".noqueue"}, {o_busy, o_vld}, 2'b00);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        bit          seen;
        rst = 1'b1;
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 16'd0, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        snap(1'b0);
        chk("rst.vld", o_vld, 0);
        chk("rst.gcd", o_gcd, 0);
        chk("rst.lcm", o_lcm, 0);
        chk("rst.in_rdy", o_inrdy, 1);
        chk("rst.busy", o_busy, 0);
        rst = 1'b0;
        tick();

        xact(1'b0, 16'd12,  16'd18,  0, "g12_18", 16);
        xact(1'b0, 16'd0,   16'd7,   0, "zero_b7", 0);
        xact(1'b0, 16'd0,   16'd0,   0, "zero_00", 0);
        xact(1'b0, 16'd7,   16'd0,   0, "zero_a7", 0);
        xact(1'b0, 16'd255, 16'd254, 0, "g255_254", 0);
        xact(1'b0, 16'd128, 16'd64,  0, "g128_64", 20);
        xact(1'b0, 16'd21,  16'd6,   5, "bp21_6", 0);

        // Abort mid-REDUCE: accept, then reset a few cycles in.
        drive(1'b0, 16'd255, 16'd254, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'd255, 16'd254, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        snap(1'b0);
        chk("abort.vld", o_vld, 0);
        chk("abort.gcd", o_gcd, 0);
        chk("abort.lcm", o_lcm, 0);
        chk("abort.in_rdy", o_inrdy, 1);
        chk("abort.busy", o_busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(); snap(1'b0);
            if (o_vld || o_busy) seen = 1'b1;
        end
        chk("abort.quiet", seen, 0);
        xact(1'b0, 16'd9, 16'd6, 0, "g9_6", 0);

        xact(1'b1, 16'hFFFF, 16'hFFFF, 0, "w16_max", 0);
        xact(1'b1, 16'd0,    16'hFFFF, 0, "w16_zero", 0);
        xact(1'b1, 16'h8000, 16'h4000, 2, "w16_pow2", 0);

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            if ((i % 7) == 3) rb = 16'(ra * $urandom_range(1, 3)) & 16'h00FF;
            xact(1'b0, ra, rb, int'($urandom_range(0, 2)), "rnd8", 0);
        end
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ((i % 5) == 1) begin
                ra = ra << $urandom_range(0, 6);
                rb = rb << $urandom_range(0, 6);
            end
            xact(1'b1, ra, rb, int'($urandom_range(0, 2)), "rnd16", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
